// File: rtl/whack_pkg.sv
// whack_pkg: shared definitions for the whack-a-mole controller and its
// score datapath.
//   state_e     : game phase codes (3 bits), the same codes the datapath decodes
//   LFSR_TAPS   : feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   hole_t      : 2-bit hole index
//   mole_state(): maps a hole index to its MOLEk state code
package whack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_GAME  = 3'b001,
        ST_MOLE0 = 3'b010,
        ST_MOLE1 = 3'b011,
        ST_MOLE2 = 3'b100,
        ST_MOLE3 = 3'b101,
        ST_OVER  = 3'b110
    } state_e;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef logic [1:0] hole_t;

    // MOLE codes are contiguous, so MOLEk = MOLE0 + k.
    function automatic state_e mole_state(input hole_t h);
        logic [2:0] code;
        code = 3'(ST_MOLE0) + {1'b0, h};
        return state_e'(code);
    endfunction

endpackage

// File: rtl/whack_lfsr.sv
// whack_lfsr: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing every clock.
// Maximal-length polynomial, so a nonzero seed never reaches 8'h00.
//   Parameter SEED : nonzero value loaded while Reset is low
//   clk     in  1  system clock
//   Reset   in  1  asynchronous active-low reset
//   o_value out 8  current LFSR value
module whack_lfsr
    import whack_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       Reset,
    output logic [7:0] o_value
);

    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/whack_control.sv
// whack_control: game sequencer for the whack-a-mole score datapath.
// Parameters: ROUNDS (mole appearances per game, 1..255), LFSR_SEED (nonzero).
// Ports:
//   clk            in  1  system clock
//   Reset          in  1  asynchronous active-low reset
//   start          in  1  player start request (level or pulse, edge-detected)
//   enable_control in  1  one-cycle "phase done" pulse from the datapath
//   state          out 3  game phase code (whack_pkg::state_e)
//   mole_onehot    out 4  lit hole, zero outside MOLE states
//   round_count    out 8  completed mole rounds in the current game
//   game_over      out 1  high while in OVER
// Build option: WHACK_NO_REPEAT_EN - when defined, a hole pick equal to the
// previous mole's hole is bumped to the next hole (mod 4).
//
// state  | meaning
// IDLE   | waiting for a start edge
// GAME   | between moles, waiting for the datapath to pick the next mole
// MOLEk  | hole k lit, waiting for the datapath to finish the round
// OVER   | ROUNDS moles done, round_count frozen until the next start edge
module whack_control
    import whack_pkg::*;
#(
    parameter int         ROUNDS    = 10,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       enable_control,
    output logic [2:0] state,
    output logic [3:0] mole_onehot,
    output logic [7:0] round_count,
    output logic       game_over
);

    localparam logic [7:0] ROUNDS_L = 8'(ROUNDS);

    state_e     r_state;
    logic [7:0] r_round;
    logic       r_start_d;

    state_e     w_next_state;
    logic [7:0] w_next_round;
    logic [7:0] w_round_inc;
    logic       w_start_evt;
    logic [7:0] w_lfsr;
    hole_t      w_pick;
    hole_t      w_hole;
    logic       w_lfsr_unused;

    whack_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .Reset   (Reset),
        .o_value (w_lfsr)
    );

    assign w_pick        = w_lfsr[1:0];
    assign w_lfsr_unused = ^w_lfsr[7:2];
    assign w_start_evt   = start & ~r_start_d;
    assign w_round_inc   = r_round + 8'd1;

`ifdef WHACK_NO_REPEAT_EN
    hole_t r_prev_hole;

    assign w_hole = (w_pick == r_prev_hole) ? hole_t'(w_pick + 2'd1) : w_pick;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_prev_hole <= '0;
        end else if (r_state == ST_GAME && enable_control) begin
            r_prev_hole <= w_hole;
        end
    end
`else
    assign w_hole = w_pick;
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_round   <= '0;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_round   <= w_next_round;
            r_start_d <= start;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_round = r_round;
        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_next_state = ST_GAME;
                    w_next_round = '0;
                end
            end
            ST_GAME: begin
                if (enable_control) begin
                    w_next_state = mole_state(w_hole);
                end
            end
            ST_MOLE0, ST_MOLE1, ST_MOLE2, ST_MOLE3: begin
                if (enable_control) begin
                    w_next_round = w_round_inc;
                    w_next_state = (w_round_inc == ROUNDS_L) ? ST_OVER : ST_GAME;
                end
            end
            ST_OVER: begin
                if (w_start_evt) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                // Unused code 3'b111 recovers to IDLE.
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mole_onehot = 4'b0000;
        case (r_state)
            ST_MOLE0: mole_onehot = 4'b0001;
            ST_MOLE1: mole_onehot = 4'b0010;
            ST_MOLE2: mole_onehot = 4'b0100;
            ST_MOLE3: mole_onehot = 4'b1000;
            default:  mole_onehot = 4'b0000;
        endcase
    end

    assign state       = r_state;
    assign round_count = r_round;
    assign game_over   = (r_state == ST_OVER);

endmodule

// File: tb/tb_whack_control.sv
// tb_whack_control: two instances (ROUNDS=10 and ROUNDS=3) driven by the same
// stimulus, each followed by a game-rule model checked on every falling edge,
// plus directed literal checks of the key scenarios.
module tb_whack_control;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b0;
    logic       enable_control = 1'b0;

    logic [2:0] st_a, st_b;
    logic [3:0] mo_a, mo_b;
    logic [7:0] rc_a, rc_b;
    logic       go_a, go_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    whack_control #(.ROUNDS(10), .LFSR_SEED(8'hA5)) dut_a (
        .clk            (clk),
        .Reset          (Reset),
        .start          (start),
        .enable_control (enable_control),
        .state          (st_a),
        .mole_onehot    (mo_a),
        .round_count    (rc_a),
        .game_over      (go_a)
    );

    whack_control #(.ROUNDS(3), .LFSR_SEED(8'hA5)) dut_b (
        .clk            (clk),
        .Reset          (Reset),
        .start          (start),
        .enable_control (enable_control),
        .state          (st_b),
        .mole_onehot    (mo_b),
        .round_count    (rc_b),
        .game_over      (go_b)
    );

    // ---------------- game-rule model ----------------
    localparam int P_IDLE = 0, P_GAME = 1, P_MOLE = 2, P_OVER = 3;

    int         m_phase [2];
    int         m_hole  [2];
    int         m_rc    [2];
    int         m_prev  [2];
    int         m_rounds[2] = '{10, 3};
    logic [7:0] m_lfsr  [2];
    logic       m_sprev [2];

    function automatic int pick_of(input int i);
        int raw;
        raw = int'(m_lfsr[i][1:0]);
`ifdef WHACK_NO_REPEAT_EN
        if (raw == m_prev[i]) raw = (raw + 1) % 4;
`endif
        return raw;
    endfunction

    function automatic int exp_code(input int i);
        case (m_phase[i])
            P_GAME:  return 1;
            P_MOLE:  return 2 + m_hole[i];
            P_OVER:  return 6;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge Reset) begin : model
        bit evt;
        int h;
        for (int i = 0; i < 2; i++) begin
            if (!Reset) begin
                m_phase[i] = P_IDLE;
                m_hole[i]  = 0;
                m_rc[i]    = 0;
                m_prev[i]  = 0;
                m_lfsr[i]  = 8'hA5;
                m_sprev[i] = 1'b0;
            end else begin
                evt = start && !m_sprev[i];
                h   = pick_of(i);
                case (m_phase[i])
                    P_IDLE: if (evt) begin
                        m_phase[i] = P_GAME;
                        m_rc[i]    = 0;
                    end
                    P_GAME: if (enable_control) begin
                        m_phase[i] = P_MOLE;
                        m_hole[i]  = h;
                        m_prev[i]  = h;
                    end
                    P_MOLE: if (enable_control) begin
                        m_rc[i]    = m_rc[i] + 1;
                        m_phase[i] = (m_rc[i] == m_rounds[i]) ? P_OVER : P_GAME;
                    end
                    default: if (evt) m_phase[i] = P_IDLE;
                endcase
                m_sprev[i] = start;
                m_lfsr[i]  = {m_lfsr[i][6:0],
                              m_lfsr[i][7] ^ m_lfsr[i][5] ^ m_lfsr[i][4] ^ m_lfsr[i][3]};
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_state_a", int'(st_a), exp_code(0));
        chk("cmp_mole_a",  int'(mo_a), (m_phase[0] == P_MOLE) ? (1 << m_hole[0]) : 0);
        chk("cmp_round_a", int'(rc_a), m_rc[0]);
        chk("cmp_over_a",  int'(go_a), (m_phase[0] == P_OVER) ? 1 : 0);
        chk("cmp_state_b", int'(st_b), exp_code(1));
        chk("cmp_mole_b",  int'(mo_b), (m_phase[1] == P_MOLE) ? (1 << m_hole[1]) : 0);
        chk("cmp_round_b", int'(rc_b), m_rc[1]);
        chk("cmp_over_b",  int'(go_b), (m_phase[1] == P_OVER) ? 1 : 0);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_en();
        enable_control = 1'b1;
        tick();
        enable_control = 1'b0;
    endtask

    // Waits (bounded) until instance A's next GAME->MOLE would land on target.
    task automatic wait_hole(input int target, input bit raw);
        for (int c = 0; c < 300; c++) begin
            if ((raw ? int'(m_lfsr[0][1:0]) : pick_of(0)) == target) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL wait_hole timeout target=%0d", target);
    endtask

    initial begin
        int starts;
        int prev_st;

        // reset state
        tick(3);
        chk("rst_state", int'(st_a), 0);
        chk("rst_mole",  int'(mo_a), 0);
        chk("rst_round", int'(rc_a), 0);
        chk("rst_over",  int'(go_a), 0);
        Reset = 1'b1;
        tick();

        // start pulse, then 9 cycles in GAME
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(8);
        chk("start_state_a", int'(st_a), 1);
        chk("start_round_a", int'(rc_a), 0);
        chk("start_mole_a",  int'(mo_a), 0);
        chk("start_over_a",  int'(go_a), 0);
        chk("start_state_b", int'(st_b), 1);

        // pick 2 -> MOLE2, then back to GAME with one round done
        wait_hole(2, 1'b1);
        pulse_en();
        chk("mole2_state", int'(st_a), 4);
        chk("mole2_onehot", int'(mo_a), 4);
        tick();
        pulse_en();
        chk("mole2_exit_state", int'(st_a), 1);
        chk("mole2_exit_round", int'(rc_a), 1);

        // ROUNDS=3 instance finishes after two more mole rounds
        pulse_en(); tick(); pulse_en(); tick();
        pulse_en(); tick(); pulse_en();
        chk("over_state_b", int'(st_b), 6);
        chk("over_flag_b",  int'(go_b), 1);
        chk("over_round_b", int'(rc_b), 3);
        chk("game_round_a", int'(rc_a), 3);
        repeat (4) begin
            tick();
            pulse_en();
        end
        chk("over_hold_state_b", int'(st_b), 6);
        chk("over_hold_round_b", int'(rc_b), 3);
        chk("game_round5_a", int'(rc_a), 5);
        chk("game_state5_a", int'(st_a), 1);

        // asynchronous reset in MOLE2 with five rounds done
        wait_hole(2, 1'b0);
        pulse_en();
        chk("pre_rst_state", int'(st_a), 4);
        chk("pre_rst_round", int'(rc_a), 5);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_state", int'(st_a), 0);
        chk("async_rst_round", int'(rc_a), 0);
        chk("async_rst_mole",  int'(mo_a), 0);
        chk("async_rst_state_b", int'(st_b), 0);
        tick(2);
        Reset = 1'b1;
        tick();
        chk("post_rst_idle", int'(st_a), 0);

        // start held high 20 cycles -> a single IDLE->GAME
        start   = 1'b1;
        starts  = 0;
        prev_st = int'(st_a);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (prev_st == 0 && int'(st_a) == 1) starts++;
            prev_st = int'(st_a);
        end
        chk("held_start_count", starts, 1);
        chk("held_start_state", int'(st_a), 1);
        start = 1'b0;
        tick();

        // start pulse in MOLE1 is ignored
        wait_hole(1, 1'b0);
        pulse_en();
        chk("mole1_state", int'(st_a), 3);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mole1_start_ignored", int'(st_a), 3);

        // two consecutive moles picked with raw hole 3
        pulse_en();
        wait_hole(3, 1'b1);
        pulse_en();
        chk("first_pick3_state", int'(st_a), 5);
        tick();
        pulse_en();
        wait_hole(3, 1'b1);
        pulse_en();
`ifdef WHACK_NO_REPEAT_EN
        chk("second_pick3_state", int'(st_a), 2);
`else
        chk("second_pick3_state", int'(st_a), 5);
`endif

        // B reaches OVER; start returns it to IDLE keeping its count
        pulse_en();
        chk("b_over_again", int'(st_b), 6);
        chk("b_round_final", int'(rc_b), 3);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_over_to_idle", int'(st_b), 0);
        chk("b_idle_round_hold", int'(rc_b), 3);
        chk("a_game_ignores_start", int'(st_a), 1);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
